// File: rtl/gate_pkg.sv
// Shared definitions for the selectable N-input gate and the blocks that consume its results.
package gate_pkg;

    typedef logic [1:0] gate_sel_t;

    localparam gate_sel_t GATE_AND  = 2'b00;
    localparam gate_sel_t GATE_XOR  = 2'b01;
    localparam gate_sel_t GATE_XNOR = 2'b10;
    localparam gate_sel_t GATE_OR   = 2'b11;

    // Input width of the reference gate used when generating stimulus.
    localparam int GATE_N = 4;

    // Reference behaviour of the selectable gate over its GATE_N inputs.
    function automatic logic gate_eval(input logic [GATE_N-1:0] vec, input gate_sel_t sel);
        logic res;
        case (sel)
            GATE_AND:  res = &vec;
            GATE_XOR:  res = ^vec;
            GATE_XNOR: res = ~^vec;
            GATE_OR:   res = |vec;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gate_result_packer_if.sv
// Handshake bundle between the gate result producer, the packer and the word consumer.
interface gate_result_packer_if #(parameter int W = 8);
    import gate_pkg::*;

    localparam int LW = $clog2(W + 1);

    logic            in_valid;
    logic            in_ready;
    logic            in_bit;
    gate_sel_t       in_sel;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_word;
    logic [LW-1:0]   out_len;
    logic [LW-1:0]   out_ones;
    gate_sel_t       out_sel;
    logic            out_mixed;

    // Environment side: produces result bits and consumes packed words.
    modport master (
        output in_valid, in_bit, in_sel, flush, out_ready,
        input  in_ready, out_valid, out_word, out_len, out_ones, out_sel, out_mixed
    );

    // Packer side.
    modport slave (
        input  in_valid, in_bit, in_sel, flush, out_ready,
        output in_ready, out_valid, out_word, out_len, out_ones, out_sel, out_mixed
    );

endinterface

// File: rtl/gate_result_packer.sv
// Packs consecutive gate result bits into words tagged with length, ones count and select info.
// One accumulator fills while the output register holds the previous word for the consumer.
module gate_result_packer
    import gate_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_result_packer_if.slave   bus
);

    localparam int LW = $clog2(W + 1);

    logic [W-1:0]  acc_q,       acc_d;
    logic [LW-1:0] fill_q,      fill_d;
    logic [LW-1:0] ones_q,      ones_d;
    gate_sel_t     cur_sel_q,   cur_sel_d;
    logic          mixed_q,     mixed_d;
    logic          pend_q,      pend_d;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_word_q,  out_word_d;
    logic [LW-1:0] out_len_q,   out_len_d;
    logic [LW-1:0] out_ones_q,  out_ones_d;
    gate_sel_t     out_sel_q,   out_sel_d;
    logic          out_mixed_q, out_mixed_d;

    logic          in_ready_s;
    logic          accept_s;
    logic          closing_s;
    logic          slot_free_s;

    // Ready depends only on held state; a full accumulator is always pending, so pend alone gates it in practice.
    assign in_ready_s = !rst && !pend_q && (fill_q < LW'(W));
    assign accept_s   = bus.in_valid && in_ready_s;

    // Next-state for the accumulator, the close/move decision and the output register.
    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        ones_d      = ones_q;
        cur_sel_d   = cur_sel_q;
        mixed_d     = mixed_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_len_d   = out_len_q;
        out_ones_d  = out_ones_q;
        out_sel_d   = out_sel_q;
        out_mixed_d = out_mixed_q;

        if (accept_s) begin
            for (int i = 0; i < W; i++) begin
                acc_d[i] = (LW'(i) == fill_q) ? bus.in_bit : acc_q[i];
            end
            fill_d = fill_q + LW'(1);
            ones_d = ones_q + {{(LW-1){1'b0}}, bus.in_bit};
            if (fill_q == '0) begin
                cur_sel_d = bus.in_sel;
                mixed_d   = 1'b0;
            end else begin
                mixed_d   = mixed_q | (bus.in_sel != cur_sel_q);
            end
        end else begin
            acc_d = acc_q;
        end

        // A flush counts the bit accepted in the same cycle; an already pending word ignores it.
        closing_s   = !pend_q && ((accept_s && (fill_q == LW'(W - 1))) ||
                                  (bus.flush && (fill_d != '0)));
        slot_free_s = !out_valid_q || bus.out_ready;

        if ((closing_s || pend_q) && slot_free_s) begin
            out_valid_d = 1'b1;
            out_word_d  = acc_d;
            out_len_d   = fill_d;
            out_ones_d  = ones_d;
            out_sel_d   = cur_sel_d;
            out_mixed_d = mixed_d;
            acc_d       = '0;
            fill_d      = '0;
            ones_d      = '0;
            cur_sel_d   = GATE_AND;
            mixed_d     = 1'b0;
            pend_d      = 1'b0;
        end else if (closing_s || pend_q) begin
            pend_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset that discards any partial or held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            fill_q      <= '0;
            ones_q      <= '0;
            cur_sel_q   <= GATE_AND;
            mixed_q     <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_len_q   <= '0;
            out_ones_q  <= '0;
            out_sel_q   <= GATE_AND;
            out_mixed_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            ones_q      <= ones_d;
            cur_sel_q   <= cur_sel_d;
            mixed_q     <= mixed_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_len_q   <= out_len_d;
            out_ones_q  <= out_ones_d;
            out_sel_q   <= out_sel_d;
            out_mixed_q <= out_mixed_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_ones  = out_ones_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_mixed = out_mixed_q;

endmodule

// File: tb/tb_gate_result_packer.sv
// Bench for gate_result_packer (W=4): directed scenarios plus random traffic against a word-queue model.
module tb_gate_result_packer;
    import gate_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [3:0] word;
        logic [2:0] len;
        logic [2:0] ones;
        logic [1:0] sel;
        logic       mixed;
    } wrd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wrd_t       exp_q[$];   // closed words not yet taken: [0] is in the output slot, [1] is pending
    logic       cur_b[$];   // bits of the word being filled
    logic [1:0] cur_s[$];

    gate_result_packer_if #(.W(W)) bus ();

    gate_result_packer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic wrd_t pack_cur();
        wrd_t w;
        int   n;
        w = '0;
        n = 0;
        for (int i = 0; i < cur_b.size(); i++) begin
            w.word[i] = cur_b[i];
            n += int'(cur_b[i]);
            if (cur_s[i] != cur_s[0]) w.mixed = 1'b1;
        end
        w.len  = 3'(cur_b.size());
        w.ones = 3'(n);
        w.sel  = cur_s[0];
        return w;
    endfunction

    // One clock: predict handshakes from the model, advance the model, then compare.
    task automatic do_edge();
        logic acc;
        logic xfr;
        wrd_t w;
        acc = bus.in_valid && !rst && (exp_q.size() < 2);
        xfr = (exp_q.size() > 0) && bus.out_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            cur_b.delete();
            cur_s.delete();
        end else begin
            if (xfr) w = exp_q.pop_front();
            if (acc) begin
                cur_b.push_back(bus.in_bit);
                cur_s.push_back(bus.in_sel);
            end
            if (cur_b.size() == W || (bus.flush && cur_b.size() > 0)) begin
                exp_q.push_back(pack_cur());
                cur_b.delete();
                cur_s.delete();
            end
        end
        #1;
        if (rst) begin
            chk("rst_in_ready",  bus.in_ready,  0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_word",  bus.out_word,  0);
            chk("rst_out_len",   bus.out_len,   0);
            chk("rst_out_ones",  bus.out_ones,  0);
            chk("rst_out_sel",   bus.out_sel,   0);
            chk("rst_out_mixed", bus.out_mixed, 0);
        end else begin
            chk("in_ready",  bus.in_ready,  (exp_q.size() < 2) ? 1 : 0);
            chk("out_valid", bus.out_valid, (exp_q.size() > 0) ? 1 : 0);
            if (exp_q.size() > 0) begin
                chk("out_word",  bus.out_word,  exp_q[0].word);
                chk("out_len",   bus.out_len,   exp_q[0].len);
                chk("out_ones",  bus.out_ones,  exp_q[0].ones);
                chk("out_sel",   bus.out_sel,   exp_q[0].sel);
                chk("out_mixed", bus.out_mixed, exp_q[0].mixed);
            end
        end
    endtask

    task automatic step(input logic v, input logic b, input logic [1:0] s,
                        input logic f, input logic ordy);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.in_sel    = s;
        bus.flush     = f;
        bus.out_ready = ordy;
        do_edge();
    endtask

    initial begin
        logic [3:0] pat;
        logic [3:0] vec;
        logic [1:0] sel;

        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_sel    = 2'b00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // Full word 1,0,1,1 with XOR select.
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_word",  bus.out_word,  4'b1101);
        chk("t1_len",   bus.out_len,   4);
        chk("t1_ones",  bus.out_ones,  3);
        chk("t1_sel",   bus.out_sel,   2'b01);
        chk("t1_mixed", bus.out_mixed, 0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // Partial word closed by a flush on the 2nd bit, then a flush with nothing filled.
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
        chk("t2_word", bus.out_word, 4'b0011);
        chk("t2_len",  bus.out_len,  2);
        chk("t2_ones", bus.out_ones, 2);
        step(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("t2_empty_flush", bus.out_valid, 0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t2_empty_flush2", bus.out_valid, 0);

        // Consumer stalled: 10 bits offered, 8 accepted, second word pending.
        pat = 4'b0011;
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 2'b11, 1'b0, 1'b0);
        pat = 4'b1010;
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 2'b11, 1'b0, 1'b0);
        chk("t3_ready_low", bus.in_ready, 0);
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("t3_held_word", bus.out_word, 4'b0011);
        chk("t3_ready_low2", bus.in_ready, 0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t3_second_word", bus.out_word, 4'b1010);
        chk("t3_ready_back",  bus.in_ready, 1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t3_drained", bus.out_valid, 0);

        // Mixed select tagging.
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t4_sel",   bus.out_sel,   2'b00);
        chk("t4_mixed", bus.out_mixed, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        chk("t4b_sel",   bus.out_sel,   2'b10);
        chk("t4b_mixed", bus.out_mixed, 0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // Reset with a held word and fill=3 discards both.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t5_after_rst", bus.out_valid, 0);
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 2'b10, 1'b0, 1'b1);
        chk("t5_new_word", bus.out_word, 4'b0110);
        chk("t5_new_len",  bus.out_len,  4);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t5_single", bus.out_valid, 0);

        // Random traffic from the reference gate.
        for (int n = 0; n < 500; n++) begin
            vec = 4'($urandom);
            sel = 2'($urandom);
            step(($urandom_range(0, 3) != 0), gate_eval(vec, sel), sel,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 6; n++) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("final_drained", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
